if_id_queue: RTL
================

// Module: if_id_queue
// PURPOSE
//  Decoupling queue between instruction fetch and decode. Accepts (PC, instruction) pairs
//  from fetch over a valid/ready handshake and buffers up to DEPTH entries. Presents the
//  oldest entry to decode with its MIPS fields split out. Flush discards all entries when a
//  jump, jr or taken branch redirects the PC.
// PARAMETERS
//  DEPTH    2   entries; power of two, >= 2
//  PC_W     32  PC width (word address; fetch advances PC by +1)
//  INSTR_W  32  instruction width; fixed MIPS encoding
// PORTS
//  clk         in   1        rising-edge clock
//  rst_n       in   1        asynchronous reset, active-low
//  in_valid    in   1        fetch offers in_pc/in_instr this cycle
//  in_ready    out  1        queue can accept this cycle
//  in_pc       in   PC_W     PC of the offered instruction
//  in_instr    in   INSTR_W  offered instruction word
//  flush       in   1        discard all stored entries and this cycle's push
//  out_valid   out  1        head entry valid
//  out_ready   in   1        decode consumes head this cycle
//  out_pc      out  PC_W     head PC
//  out_instr   out  INSTR_W  head instruction
//  opcode      out  6        out_instr[31:26]
//  rs, rt, rd  out  5 each   [25:21], [20:16], [15:11]
//  shamt       out  5        [10:6]
//  funct       out  6        [5:0]
//  imm16       out  16       [15:0]
//  target26    out  26       [25:0]
//  hint        out  4        {is_jal, is_j, is_jr, is_bne_beq}; see CONFIGURATION
// BEHAVIOUR
//  - Reset (async assert, sync release): count=0, rd_ptr=wr_ptr=0, out_valid=0.
//    out_pc, out_instr, fields and hint = 0. Storage contents are don't-care.
//  - Push when in_valid && in_ready && !flush. Pop when out_valid && out_ready && !flush.
//  - in_ready = (count != DEPTH). It depends only on registered state, with no combinational
//    path from out_ready. Full queue: no push, even if a pop occurs the same cycle.
//  - out_valid = (count != 0). No bypass: minimum latency is 1 cycle from push to out_valid.
//  - Push and pop in the same cycle: count unchanged, both pointers advance.
//  - Pointers are log2(DEPTH) bits and wrap modulo DEPTH. Count is log2(DEPTH)+1 bits.
//  - flush: on the next edge count=0 and rd_ptr=wr_ptr=0. The same-cycle push and pop are
//    both ignored. flush wins over every other event.
//  - Output fields are pure slices of the storage entry at rd_ptr. They are zero when
//    count==0, so they never expose stale data.
//  - Holding rule: while out_valid && !out_ready, the outputs stay stable.
//  - Fetch must hold in_pc/in_instr stable while in_valid && !in_ready.
//  - Reset asserted mid-operation drops all entries immediately. No partial state survives.
// CONFIGURATION
//  IFID_PREDECODE_EN defined:
//   - hint is computed on push and stored alongside each entry (4 extra bits per entry).
//   - is_bne_beq = opcode 6'h04 or 6'h05. is_j = 6'h02. is_jal = 6'h03.
//   - is_jr = opcode 6'h00 && funct 6'h08.
//   - Values are zero when count==0.
//  IFID_PREDECODE_EN undefined:
//   - hint tied to 4'b0; no storage for it.
// STRUCTURE
//  - Shared package ifid_pkg: opcode/funct localparams (OP_RTYPE, OP_J, OP_JAL, OP_BEQ,
//    OP_BNE, FN_JR), field bit-position localparams, and hint bit indices.
//  - One sub-module, ifid_field_split: combinational instr -> fields (+ hint when enabled).
//    It is used at the head read port, and at the write port for hint.
// TESTING
//  1. Reset:
//     rst_n=0 mid-stream -> out_valid=0, in_ready=1 and all outputs 0 asynchronously.
//  2. Single push:
//     in_pc=0x10, in_instr=0x8C220004 pushed at cycle t.
//     -> out_valid=1 at t+1, opcode=0x23, rs=1, rt=2, imm16=0x0004.
//  3. Fill and stall:
//     4 back-to-back pushes, out_ready=0, DEPTH=2.
//     -> in_ready=0 after 2 accepts; the 3rd is held.
//     Then out_ready=1 -> entries exit in order PC 0x10, 0x11, 0x12, with no loss or duplication.
//  4. Simultaneous push and pop at count=1 for 8 cycles:
//     -> count stays 1, pointers wrap, PCs are output in strict order.
//  5. Flush:
//     count=2 with flush=1 and in_valid=1 in the same cycle -> next cycle count=0, out_valid=0.
//     The pushed entry never appears.
//  6. Predecode (IFID_PREDECODE_EN):
//     push 0x03E00008 -> hint=4'b0010.
//     push 0x0C000040 -> hint=4'b1000.
//     push 0x14A0FFFE -> hint=4'b0001.
//     Without the macro, all three -> hint=0.

Source files
------------

// File: rtl/ifid_pkg.sv
// Shared MIPS encoding constants for the IF/ID queue: opcodes, funct codes,
// instruction field positions and predecode hint bit indices.
package ifid_pkg;

   localparam logic [5:0] OP_RTYPE = 6'h00;
   localparam logic [5:0] OP_J     = 6'h02;
   localparam logic [5:0] OP_JAL   = 6'h03;
   localparam logic [5:0] OP_BEQ   = 6'h04;
   localparam logic [5:0] OP_BNE   = 6'h05;
   localparam logic [5:0] FN_JR    = 6'h08;

   localparam int OPCODE_LSB = 26;
   localparam int RS_LSB     = 21;
   localparam int RT_LSB     = 16;
   localparam int RD_LSB     = 11;
   localparam int SHAMT_LSB  = 6;
   localparam int FUNCT_LSB  = 0;
   localparam int IMM_LSB    = 0;
   localparam int TARGET_LSB = 0;

   // hint = {is_jal, is_j, is_jr, is_bne_beq}
   localparam int HINT_W   = 4;
   localparam int HINT_BR  = 0;
   localparam int HINT_JR  = 1;
   localparam int HINT_J   = 2;
   localparam int HINT_JAL = 3;

endpackage

// File: rtl/ifid_field_split.sv
// Combinational MIPS field splitter. It also produces the control-flow hint
// when IFID_PREDECODE_EN is defined, and drives that hint to zero otherwise.
module ifid_field_split
   import ifid_pkg::*;
(
   input  logic [31:0]       instr,
   output logic [5:0]        opcode,
   output logic [4:0]        rs,
   output logic [4:0]        rt,
   output logic [4:0]        rd,
   output logic [4:0]        shamt,
   output logic [5:0]        funct,
   output logic [15:0]       imm16,
   output logic [25:0]       target26,
   output logic [HINT_W-1:0] hint
);

   assign opcode   = instr[OPCODE_LSB +: 6];
   assign rs       = instr[RS_LSB     +: 5];
   assign rt       = instr[RT_LSB     +: 5];
   assign rd       = instr[RD_LSB     +: 5];
   assign shamt    = instr[SHAMT_LSB  +: 5];
   assign funct    = instr[FUNCT_LSB  +: 6];
   assign imm16    = instr[IMM_LSB    +: 16];
   assign target26 = instr[TARGET_LSB +: 26];

`ifdef IFID_PREDECODE_EN
   always_comb begin
      hint           = '0;
      hint[HINT_BR]  = (opcode == OP_BEQ) || (opcode == OP_BNE);
      hint[HINT_J]   = (opcode == OP_J);
      hint[HINT_JAL] = (opcode == OP_JAL);
      hint[HINT_JR]  = (opcode == OP_RTYPE) && (funct == FN_JR);
   end
`else
   assign hint = '0;
`endif

endmodule

// File: rtl/if_id_queue.sv
// IF/ID decoupling queue: circular buffer of (PC, instruction) pairs with the head
// presented to decode as split MIPS fields. Optional macro: IFID_PREDECODE_EN.
module if_id_queue
   import ifid_pkg::*;
#(
   parameter int DEPTH   = 2,
   parameter int PC_W    = 32,
   parameter int INSTR_W = 32
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [PC_W-1:0]    in_pc,
   input  logic [INSTR_W-1:0] in_instr,
   input  logic               flush,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [PC_W-1:0]    out_pc,
   output logic [INSTR_W-1:0] out_instr,
   output logic [5:0]         opcode,
   output logic [4:0]         rs,
   output logic [4:0]         rt,
   output logic [4:0]         rd,
   output logic [4:0]         shamt,
   output logic [5:0]         funct,
   output logic [15:0]        imm16,
   output logic [25:0]        target26,
   output logic [3:0]         hint
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;
   localparam logic [CNT_W-1:0] FULL = CNT_W'(DEPTH);

   logic [PC_W-1:0]    pc_mem    [DEPTH];
   logic [INSTR_W-1:0] instr_mem [DEPTH];
   logic [PTR_W-1:0]   rd_ptr, wr_ptr;
   logic [CNT_W-1:0]   count;
   logic               push, pop;
   logic [INSTR_W-1:0] head_instr;
   logic [HINT_W-1:0]  unused_rd_hint;

   // Handshake: a beat transfers on a rising edge where valid && ready are both high
   // and flush is low; ready never depends on the other side's valid or ready.
   assign in_ready  = (count != FULL);
   assign out_valid = (count != '0);
   assign push      = in_valid && in_ready && !flush;
   assign pop       = out_valid && out_ready && !flush;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count  <= '0;
         rd_ptr <= '0;
         wr_ptr <= '0;
      end else if (flush) begin
         count  <= '0;
         rd_ptr <= '0;
         wr_ptr <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + 1'b1;
         if (pop)  rd_ptr <= rd_ptr + 1'b1;
         case ({push, pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   // Storage needs no reset: nothing reads it while count is zero.
   always_ff @(posedge clk) begin
      if (push) begin
         pc_mem[wr_ptr]    <= in_pc;
         instr_mem[wr_ptr] <= in_instr;
      end
   end

   assign out_pc     = out_valid ? pc_mem[rd_ptr]    : '0;
   assign head_instr = out_valid ? instr_mem[rd_ptr] : '0;
   assign out_instr  = head_instr;

   ifid_field_split u_rd_split (
      .instr    (head_instr),
      .opcode   (opcode),
      .rs       (rs),
      .rt       (rt),
      .rd       (rd),
      .shamt    (shamt),
      .funct    (funct),
      .imm16    (imm16),
      .target26 (target26),
      .hint     (unused_rd_hint)
   );

`ifdef IFID_PREDECODE_EN
   logic [HINT_W-1:0] hint_mem [DEPTH];
   logic [HINT_W-1:0] wr_hint;
   logic [5:0]        unused_wr_opcode, unused_wr_funct;
   logic [4:0]        unused_wr_rs, unused_wr_rt, unused_wr_rd, unused_wr_shamt;
   logic [15:0]       unused_wr_imm16;
   logic [25:0]       unused_wr_target26;

   // Hint is decoded once at the write port so the head path is just a read.
   ifid_field_split u_wr_split (
      .instr    (in_instr),
      .opcode   (unused_wr_opcode),
      .rs       (unused_wr_rs),
      .rt       (unused_wr_rt),
      .rd       (unused_wr_rd),
      .shamt    (unused_wr_shamt),
      .funct    (unused_wr_funct),
      .imm16    (unused_wr_imm16),
      .target26 (unused_wr_target26),
      .hint     (wr_hint)
   );

   always_ff @(posedge clk) begin
      if (push) hint_mem[wr_ptr] <= wr_hint;
   end

   assign hint = out_valid ? hint_mem[rd_ptr] : '0;
`else
   assign hint = '0;
`endif

endmodule
